// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: raw buttons and live time in, counter controls and display time out.
// Contract: buttons are free-running levels and time_in is valid every cycle; all outputs are registered and meaningful every cycle.
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_lap;
  logic [31:0] time_in;
  logic        run_en;
  logic        clear;
  logic [31:0] time_out;
  logic        lap_valid;
  logic [1:0]  state;

  modport master (
    output btn_start, btn_lap, time_in,
    input  run_en, clear, time_out, lap_valid, state
  );

  modport slave (
    input  btn_start, btn_lap, time_in,
    output run_en, clear, time_out, lap_valid, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: synchronises and debounces two buttons, acts on release,
// and drives count enable, counter clear and the live/lap display selection.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  // Index 0 is start/stop, index 1 is lap/clear.
  logic [1:0] raw;
  logic [1:0] ev;

  assign raw = {bus.btn_lap, bus.btn_start};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          db_d_q;
    logic          ev_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        db_q   <= 1'b0;
        db_d_q <= 1'b0;
        ev_q   <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[b]};
        if (sync_q[SYNC_STAGES-1] == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          db_q  <= sync_q[SYNC_STAGES-1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        db_d_q <= db_q;
        // Release (debounced 1 -> 0) is the only action edge.
        ev_q   <= db_d_q & ~db_q;
      end
    end

    assign ev[b] = ev_q;
  end

  state_t      state_q;
  state_t      nxt;
  logic        clr_nxt;
  logic        lap_load;
  logic        start_ev;
  logic        lap_ev;
  logic        run_en_q;
  logic        clear_q;
  logic        lap_valid_q;
  logic [31:0] lap_q;
  logic [31:0] time_out_q;

  assign start_ev = ev[0];
  assign lap_ev   = ev[1] & ~ev[0];

  always_comb begin
    nxt      = state_q;
    clr_nxt  = 1'b0;
    lap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev)    nxt = RUN;
        else if (lap_ev) clr_nxt = 1'b1;
      end
      RUN: begin
        if (start_ev) begin
          nxt = PAUSE;
        end else if (lap_ev) begin
          nxt      = LAP;
          lap_load = 1'b1;
        end
      end
      LAP: begin
        if (start_ev)    nxt = PAUSE;
        else if (lap_ev) nxt = RUN;
      end
      PAUSE: begin
        if (start_ev) begin
          nxt = RUN;
        end else if (lap_ev) begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Counting continues in LAP; only the display is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_q       <= '0;
      time_out_q  <= '0;
    end else begin
      state_q     <= nxt;
      clear_q     <= clr_nxt;
      run_en_q    <= (nxt == RUN) || (nxt == LAP);
      lap_valid_q <= (nxt == LAP);
      if (lap_load) lap_q <= bus.time_in;
      if (nxt == LAP) time_out_q <= lap_load ? bus.time_in : lap_q;
      else            time_out_q <= bus.time_in;
    end
  end

  assign bus.state     = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.clear     = clear_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.time_out  = time_out_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: sliding-window button model plus release-driven mode table,
// compared every cycle, with literal expectations at key points of each scenario.
module tb_stopwatch_ctrl;
  localparam int DC = 4;
  localparam int SS = 2;
  localparam int H  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit rand_time = 1'b0;

  // Model state: raw samples per edge, synchronised level after each edge, accepted level.
  bit          rs[2][H];
  bit          sy[2][H];
  bit          db[2];
  bit          pend[2][2];
  int          m_state = 0;
  logic        m_clear = 1'b0;
  logic        m_run = 1'b0;
  logic        m_lapv = 1'b0;
  logic [31:0] m_lap = '0;
  logic [31:0] m_tout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  initial begin : model
    bit all_flip;
    bit fell;
    bit act[2];
    logic [31:0] t_now;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int b = 0; b < 2; b++) begin
          for (int k = 0; k < H; k++) begin
            rs[b][k] = 1'b0;
            sy[b][k] = 1'b0;
          end
          db[b] = 1'b0;
          pend[b][0] = 1'b0;
          pend[b][1] = 1'b0;
        end
        m_state = 0; m_clear = 1'b0; m_run = 1'b0; m_lapv = 1'b0;
        m_lap = '0; m_tout = '0;
      end else begin
        t_now = bus.time_in;
        for (int b = 0; b < 2; b++) begin
          // A level is accepted once the last DC synchronised samples all disagree with it.
          all_flip = 1'b1;
          for (int k = 0; k < DC; k++) if (sy[b][k] == db[b]) all_flip = 1'b0;
          fell = 1'b0;
          if (all_flip) begin
            fell  = db[b];
            db[b] = ~db[b];
          end
          act[b]     = pend[b][1];
          pend[b][1] = pend[b][0];
          pend[b][0] = fell;
          for (int k = H - 1; k > 0; k--) begin
            rs[b][k] = rs[b][k-1];
            sy[b][k] = sy[b][k-1];
          end
          rs[b][0] = (b == 0) ? bus.btn_start : bus.btn_lap;
          sy[b][0] = rs[b][SS-1];
        end
        m_clear = 1'b0;
        if (act[0]) begin
          case (m_state)
            0: m_state = 1;
            1: m_state = 3;
            2: m_state = 3;
            default: m_state = 1;
          endcase
        end else if (act[1]) begin
          case (m_state)
            0: m_clear = 1'b1;
            1: begin m_state = 2; m_lap = t_now; end
            2: m_state = 1;
            default: begin m_state = 0; m_clear = 1'b1; end
          endcase
        end
        m_run  = (m_state == 1) || (m_state == 2);
        m_lapv = (m_state == 2);
        m_tout = (m_state == 2) ? m_lap : t_now;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("state", 32'(bus.state), 32'(m_state));
      chk("run_en", 32'(bus.run_en), 32'(m_run));
      chk("clear", 32'(bus.clear), 32'(m_clear));
      chk("lap_valid", 32'(bus.lap_valid), 32'(m_lapv));
      chk("time_out", bus.time_out, m_tout);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_time) bus.time_in = $urandom;
    end
  endtask

  // Hold the selected buttons for 'hold' cycles; returns on the negedge that drives the release.
  task automatic press(input bit s, input bit l, input int hold);
    @(negedge clk);
    bus.btn_start = s;
    bus.btn_lap   = l;
    tick(hold);
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
  endtask

  task automatic count_clears(input string name);
    int c;
    c = 0;
    repeat (12) begin
      tick(1);
      c += int'(bus.clear);
    end
    chk(name, 32'(c), 32'd1);
  endtask

  initial begin : stim
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
    bus.time_in   = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_run_en", 32'(bus.run_en), 32'd0);
    chk("rst_clear", 32'(bus.clear), 32'd0);
    chk("rst_time_out", bus.time_out, 32'h0);
    chk("rst_lap_valid", 32'(bus.lap_valid), 32'd0);
    rst = 1'b1;
    tick(5);

    // Press shorter than the debounce window.
    @(negedge clk);
    bus.btn_start = 1'b1;
    tick(3);
    bus.btn_start = 1'b0;
    tick(12);
    chk("glitch_state", 32'(bus.state), 32'd0);

    rand_time = 1'b1;
    press(1'b1, 1'b0, 10);
    tick(7);
    chk("start_early", 32'(bus.state), 32'd0);
    tick(1);
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_run_en", 32'(bus.run_en), 32'd1);
    tick(5);
    press(1'b1, 1'b0, 10);
    tick(8);
    chk("pause_state", 32'(bus.state), 32'd3);
    chk("pause_run_en", 32'(bus.run_en), 32'd0);
    press(1'b1, 1'b0, 10);
    tick(8);
    chk("resume_state", 32'(bus.state), 32'd1);

    // Asynchronous reset mid-RUN.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_run_en", 32'(bus.run_en), 32'd0);
    chk("arst_clear", 32'(bus.clear), 32'd0);
    chk("arst_time_out", bus.time_out, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick(10);
    chk("post_rst_state", 32'(bus.state), 32'd0);
    press(1'b1, 1'b0, 10);
    tick(8);
    chk("restart_state", 32'(bus.state), 32'd1);

    // Lap snapshot.
    rand_time = 1'b0;
    bus.time_in = 32'h0012_3456;
    press(1'b0, 1'b1, 10);
    tick(8);
    chk("lap_state", 32'(bus.state), 32'd2);
    chk("lap_valid", 32'(bus.lap_valid), 32'd1);
    chk("lap_time_out", bus.time_out, 32'h0012_3456);
    bus.time_in = 32'h0012_3499;
    tick(2);
    chk("lap_frozen", bus.time_out, 32'h0012_3456);
    chk("lap_run_en", 32'(bus.run_en), 32'd1);
    press(1'b0, 1'b1, 10);
    tick(8);
    chk("unlap_state", 32'(bus.state), 32'd1);
    bus.time_in = 32'h0012_3500;
    tick(1);
    chk("unlap_track", bus.time_out, 32'h0012_3500);
    rand_time = 1'b1;

    // Clear from PAUSE and from IDLE.
    press(1'b1, 1'b0, 10);
    tick(8);
    chk("pause2_state", 32'(bus.state), 32'd3);
    press(1'b0, 1'b1, 10);
    count_clears("pause_clear_pulses");
    chk("cleared_state", 32'(bus.state), 32'd0);
    press(1'b0, 1'b1, 10);
    count_clears("idle_clear_pulses");
    chk("idle_state", 32'(bus.state), 32'd0);

    // Simultaneous release: start wins.
    press(1'b1, 1'b0, 10);
    tick(8);
    chk("run3_state", 32'(bus.state), 32'd1);
    press(1'b1, 1'b1, 10);
    tick(8);
    chk("both_state", 32'(bus.state), 32'd3);
    chk("both_lap_valid", 32'(bus.lap_valid), 32'd0);

    // Back-to-back events across the two buttons: PAUSE -> RUN -> LAP.
    @(negedge clk);
    bus.btn_start = 1'b1;
    bus.btn_lap   = 1'b1;
    tick(10);
    bus.btn_start = 1'b0;
    tick(1);
    bus.btn_lap = 1'b0;
    tick(7);
    chk("b2b_first", 32'(bus.state), 32'd1);
    tick(1);
    chk("b2b_second", 32'(bus.state), 32'd2);
    chk("b2b_lap_valid", 32'(bus.lap_valid), 32'd1);

    // A held button does nothing until released.
    press(1'b0, 1'b1, 30);
    chk("held_state", 32'(bus.state), 32'd2);
    tick(8);
    chk("held_release", 32'(bus.state), 32'd1);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
